// File: rtl/spcore_ctrl_if.sv
// Instruction handshake, SPCore control pins and memory port of one SPCore sequencer.
// The slave modport is the sequencer; the master side feeds instructions and answers memory.
interface spcore_ctrl_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned CNT_W   = 16
) ();

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic [3:0]         x;
  logic [3:0]         y;
  logic [3:0]         z;
  logic [15:0]        I;
  logic [3:0]         aluc;
  logic [1:0]         s2;
  logic               reg_we;
  logic               core_en;
  logic               mem_req;
  logic               mem_we;
  logic               mem_ack;
  logic               busy;
  logic               illegal_op;
  logic               mem_err;
  logic [CNT_W-1:0]   retired;

  modport slave (
    input  instr,
    input  instr_valid,
    input  mem_ack,
    output instr_ready,
    output x,
    output y,
    output z,
    output I,
    output aluc,
    output s2,
    output reg_we,
    output core_en,
    output mem_req,
    output mem_we,
    output busy,
    output illegal_op,
    output mem_err,
    output retired
  );

  modport master (
    output instr,
    output instr_valid,
    output mem_ack,
    input  instr_ready,
    input  x,
    input  y,
    input  z,
    input  I,
    input  aluc,
    input  s2,
    input  reg_we,
    input  core_en,
    input  mem_req,
    input  mem_we,
    input  busy,
    input  illegal_op,
    input  mem_err,
    input  retired
  );

endinterface

// File: rtl/spcore_ctrl.sv
// Per-core instruction sequencer: walks one decoded instruction through READ/EXEC/MEM/WB,
// drives the SPCore control pins, and tracks retirement, illegal opcodes and memory timeouts.
module spcore_ctrl #(
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input logic         clk,
  input logic         reset,
  spcore_ctrl_if.slave bus
);

  localparam logic [3:0] ALUC_CLEAR   = 4'd0;
  localparam logic [3:0] ALUC_ADD     = 4'd1;
  localparam logic [3:0] ALUC_MUL     = 4'd2;
  localparam logic [3:0] ALUC_MAD     = 4'd3;
  localparam logic [3:0] ALUC_CORE_ID = 4'd4;
  localparam logic [3:0] ALUC_N_CORES = 4'd5;

  localparam logic [1:0] MUXD_FROM_ALU = 2'd0;
  localparam logic [1:0] MUXD_FROM_I   = 2'd1;
  localparam logic [1:0] MUXD_FROM_MEM = 2'd2;

  localparam logic [3:0] OpNop     = 4'd0;
  localparam logic [3:0] OpLoadi   = 4'd1;
  localparam logic [3:0] OpAdd     = 4'd2;
  localparam logic [3:0] OpMul     = 4'd3;
  localparam logic [3:0] OpMad     = 4'd4;
  localparam logic [3:0] OpLoadcId = 4'd5;
  localparam logic [3:0] OpLoadcN  = 4'd6;
  localparam logic [3:0] OpLoad    = 4'd7;
  localparam logic [3:0] OpStore   = 4'd8;

  localparam logic [7:0] TmoLast = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StRead, StExec, StMem, StWb} state_e;

  state_e           r_state;
  logic [3:0]       r_op;
  logic [3:0]       r_x;
  logic [3:0]       r_y;
  logic [3:0]       r_z;
  logic [15:0]      r_imm;
  logic [3:0]       r_aluc;
  logic [1:0]       r_s2;
  logic             r_reg_we;
  logic             r_mem_req;
  logic             r_mem_we;
  logic             r_ready;
  logic             r_illegal;
  logic             r_mem_err;
  logic [7:0]       r_tmo;
  logic [CNT_W-1:0] r_retired;

  logic [3:0] w_op;
  assign w_op = bus.instr[31:28];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_op      <= OpNop;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_imm     <= '0;
      r_aluc    <= ALUC_CLEAR;
      r_s2      <= MUXD_FROM_ALU;
      r_reg_we  <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_ready   <= 1'b1;
      r_illegal <= 1'b0;
      r_mem_err <= 1'b0;
      r_tmo     <= '0;
      r_retired <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.instr_valid) begin
            r_op    <= w_op;
            r_x     <= bus.instr[27:24];
            r_y     <= bus.instr[23:20];
            r_z     <= bus.instr[19:16];
            r_imm   <= bus.instr[15:0];
            r_ready <= 1'b0;
            r_state <= StRead;
            // LOADI skips EXEC, so its mux setting must already be in place during READ.
            if (w_op == OpLoadi) begin
              r_aluc <= ALUC_CLEAR;
              r_s2   <= MUXD_FROM_I;
            end
            if (w_op > OpStore) r_illegal <= 1'b1;
          end
        end

        StRead: begin
          case (r_op)
            OpLoadi: begin
              r_reg_we <= 1'b1;
              r_state  <= StWb;
            end
            OpAdd, OpMul, OpMad, OpLoadcId, OpLoadcN: begin
              case (r_op)
                OpAdd:     r_aluc <= ALUC_ADD;
                OpMul:     r_aluc <= ALUC_MUL;
                OpMad:     r_aluc <= ALUC_MAD;
                OpLoadcId: r_aluc <= ALUC_CORE_ID;
                default:   r_aluc <= ALUC_N_CORES;
              endcase
              r_s2    <= MUXD_FROM_ALU;
              r_state <= StExec;
            end
            OpLoad, OpStore: begin
              if (r_op == OpLoad) r_s2 <= MUXD_FROM_MEM;
              r_mem_req <= 1'b1;
              r_mem_we  <= (r_op == OpStore);
              r_tmo     <= '0;
              r_state   <= StMem;
            end
            default: begin
              // NOP and every undefined opcode retire straight out of READ.
              r_retired <= r_retired + 1'b1;
              r_ready   <= 1'b1;
              r_state   <= StIdle;
            end
          endcase
        end

        StExec: begin
          r_reg_we <= 1'b1;
          r_state  <= StWb;
        end

        StMem: begin
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_op == OpStore) begin
              r_retired <= r_retired + 1'b1;
              r_ready   <= 1'b1;
              r_state   <= StIdle;
            end else begin
              r_reg_we <= 1'b1;
              r_state  <= StWb;
            end
          end else if (r_tmo == TmoLast) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_err <= 1'b1;
            r_ready   <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end

        StWb: begin
          r_reg_we  <= 1'b0;
          r_retired <= r_retired + 1'b1;
          r_ready   <= 1'b1;
          r_state   <= StIdle;
        end

        default: begin
          r_reg_we  <= 1'b0;
          r_mem_req <= 1'b0;
          r_ready   <= 1'b1;
          r_state   <= StIdle;
        end
      endcase
    end
  end

  assign bus.instr_ready = r_ready;
  assign bus.busy        = ~r_ready;
  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.z           = r_z;
  assign bus.I           = r_imm;
  assign bus.aluc        = r_aluc;
  assign bus.s2          = r_s2;
  assign bus.reg_we      = r_reg_we;
  // Reserved for a future stall input; the core is never held today.
  assign bus.core_en     = 1'b1;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.illegal_op  = r_illegal;
  assign bus.mem_err     = r_mem_err;
  assign bus.retired     = r_retired;

endmodule

// File: tb/tb_spcore_ctrl.sv
// Directed bench: drives instructions, answers memory, models the SPCore register file and ALU.
module tb_spcore_ctrl;

  localparam logic [3:0] ALUC_CLEAR    = 4'd0;
  localparam logic [3:0] ALUC_ADD      = 4'd1;
  localparam logic [3:0] ALUC_MUL      = 4'd2;
  localparam logic [3:0] ALUC_MAD      = 4'd3;
  localparam logic [3:0] ALUC_CORE_ID  = 4'd4;
  localparam logic [3:0] ALUC_N_CORES  = 4'd5;
  localparam logic [1:0] MUXD_FROM_ALU = 2'd0;
  localparam logic [1:0] MUXD_FROM_I   = 2'd1;
  localparam logic [1:0] MUXD_FROM_MEM = 2'd2;
  localparam logic [15:0] CORE_ID      = 16'd100;
  localparam logic [15:0] N_CORES      = 16'd200;
  localparam logic [15:0] MEM_RDATA    = 16'h1234;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  spcore_ctrl_if bus ();
  spcore_ctrl_if #(.CNT_W(3)) bus2 ();

  spcore_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  spcore_ctrl #(.CNT_W(3)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  // SPCore datapath model: register file written through MuxD.
  logic [15:0] rf [16];
  logic [15:0] wb_val;

  always_comb begin
    wb_val = '0;
    case (bus.s2)
      MUXD_FROM_I:   wb_val = bus.I;
      MUXD_FROM_MEM: wb_val = MEM_RDATA;
      default: begin
        case (bus.aluc)
          ALUC_ADD:     wb_val = rf[bus.y] + rf[bus.z];
          ALUC_MUL:     wb_val = rf[bus.y] * rf[bus.z];
          ALUC_MAD:     wb_val = rf[bus.x] + rf[bus.y] * rf[bus.z];
          ALUC_CORE_ID: wb_val = CORE_ID;
          ALUC_N_CORES: wb_val = N_CORES;
          default:      wb_val = '0;
        endcase
      end
    endcase
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (bus.reg_we) begin
      rf[bus.x] <= wb_val;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Issues one instruction, answers mem_req on the ack_at-th request cycle (0 = never),
  // and reports the cycle on which instr_ready is seen high again (1 = READ cycle).
  task automatic run_instr(input logic [3:0] op, input logic [3:0] rx, input logic [3:0] ry,
                           input logic [3:0] rz, input logic [15:0] imm, input int ack_at,
                           output int lat, output int we_cyc, output int we_at,
                           output int req_cyc, output int req_we_cyc);
    int guard;
    lat = 0; we_cyc = 0; we_at = 0; req_cyc = 0; req_we_cyc = 0;
    @(negedge clk);
    guard = 0;
    while (!bus.instr_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.instr       = {op, rx, ry, rz, imm};
    bus.instr_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
      end
      if (bus.instr_ready) begin
        lat = k;
        break;
      end
      if (bus.reg_we) begin
        we_cyc++;
        if (we_at == 0) we_at = k;
      end
      if (bus.mem_req) begin
        req_cyc++;
        if (bus.mem_we) req_we_cyc++;
        bus.mem_ack = (req_cyc == ack_at);
      end else begin
        bus.mem_ack = 1'b0;
      end
    end
    bus.mem_ack = 1'b0;
  endtask

  int lat, we_cyc, we_at, req_cyc, req_we_cyc;

  initial begin
    reset            = 1'b0;
    bus.instr        = '0;
    bus.instr_valid  = 1'b0;
    bus.mem_ack      = 1'b0;
    bus2.instr       = '0;
    bus2.instr_valid = 1'b0;
    bus2.mem_ack     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_core_en", {31'd0, bus.core_en}, 32'd1);
    check("rst_ctrl", {bus.reg_we, bus.mem_req, bus.mem_we, bus.illegal_op, bus.mem_err}, 32'd0);
    check("rst_aluc_s2", {bus.aluc, bus.s2}, {ALUC_CLEAR, MUXD_FROM_ALU});
    check("rst_sel", {bus.x, bus.y, bus.z, bus.I}, 32'd0);
    check("rst_retired", bus.retired, 32'd0);
    reset = 1'b1;

    run_instr(4'd1, 4'd0, 4'd0, 4'd0, 16'd11, 0, lat, we_cyc, we_at, req_cyc, req_we_cyc);
    check("loadi0_lat", lat, 32'd3);
    check("loadi0_we_cyc", we_cyc, 32'd1);
    check("loadi0_we_at", we_at, 32'd2);
    check("loadi0_r0", rf[0], 32'd11);
    run_instr(4'd1, 4'd1, 4'd0, 4'd0, 16'd20, 0, lat, we_cyc, we_at, req_cyc, req_we_cyc);
    check("loadi1_we_cyc", we_cyc, 32'd1);
    check("loadi1_r1", rf[1], 32'd20);
    check("loadi_retired", bus.retired, 32'd2);

    run_instr(4'd2, 4'd2, 4'd0, 4'd1, 16'd0, 0, lat, we_cyc, we_at, req_cyc, req_we_cyc);
    check("add_lat", lat, 32'd4);
    check("add_we_at", we_at, 32'd3);
    check("add_r2", rf[2], 32'd31);
    run_instr(4'd4, 4'd2, 4'd0, 4'd1, 16'd0, 0, lat, we_cyc, we_at, req_cyc, req_we_cyc);
    check("mad_lat", lat, 32'd4);
    check("mad_r2", rf[2], 32'd251);
    run_instr(4'd3, 4'd2, 4'd0, 4'd1, 16'd0, 0, lat, we_cyc, we_at, req_cyc, req_we_cyc);
    check("mul_lat", lat, 32'd4);
    check("mul_r2", rf[2], 32'd220);

    run_instr(4'd5, 4'd3, 4'd0, 4'd0, 16'd0, 0, lat, we_cyc, we_at, req_cyc, req_we_cyc);
    check("loadc_id_r3", rf[3], 32'd100);
    run_instr(4'd6, 4'd3, 4'd0, 4'd0, 16'd0, 0, lat, we_cyc, we_at, req_cyc, req_we_cyc);
    check("loadc_n_r3", rf[3], 32'd200);
    check("alu_retired", bus.retired, 32'd7);

    run_instr(4'd8, 4'd2, 4'd0, 4'd0, 16'd0, 3, lat, we_cyc, we_at, req_cyc, req_we_cyc);
    check("store_req_cyc", req_cyc, 32'd3);
    check("store_mem_we", req_we_cyc, 32'd3);
    check("store_no_we", we_cyc, 32'd0);
    check("store_lat", lat, 32'd5);
    check("store_retired", bus.retired, 32'd8);
    check("store_no_err", {31'd0, bus.mem_err}, 32'd0);

    run_instr(4'd7, 4'd4, 4'd0, 4'd0, 16'd0, 2, lat, we_cyc, we_at, req_cyc, req_we_cyc);
    check("load_req_cyc", req_cyc, 32'd2);
    check("load_mem_we", req_we_cyc, 32'd0);
    check("load_lat", lat, 32'd5);
    check("load_r4", rf[4], 32'h1234);
    check("load_retired", bus.retired, 32'd9);

    run_instr(4'd7, 4'd5, 4'd0, 4'd0, 16'd0, 0, lat, we_cyc, we_at, req_cyc, req_we_cyc);
    check("tmo_req_cyc", req_cyc, 32'd15);
    check("tmo_lat", lat, 32'd17);
    check("tmo_no_we", we_cyc, 32'd0);
    check("tmo_mem_err", {31'd0, bus.mem_err}, 32'd1);
    check("tmo_r5", rf[5], 32'd0);
    check("tmo_retired", bus.retired, 32'd9);
    check("pre_illegal", {31'd0, bus.illegal_op}, 32'd0);

    run_instr(4'd12, 4'd6, 4'd0, 4'd0, 16'd5, 0, lat, we_cyc, we_at, req_cyc, req_we_cyc);
    check("illegal_flag", {31'd0, bus.illegal_op}, 32'd1);
    check("illegal_no_we", we_cyc, 32'd0);
    check("illegal_lat", lat, 32'd2);
    check("illegal_retired", bus.retired, 32'd10);

    run_instr(4'd0, 4'd0, 4'd0, 4'd0, 16'd0, 0, lat, we_cyc, we_at, req_cyc, req_we_cyc);
    check("nop_lat", lat, 32'd2);
    check("nop_retired", bus.retired, 32'd11);

    // Reset lands on the EXEC cycle of an ADD.
    @(negedge clk);
    bus.instr       = {4'd2, 4'd2, 4'd0, 4'd1, 16'd0};
    bus.instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check("midrst_in_exec", {bus.aluc, bus.reg_we}, {ALUC_ADD, 1'b0});
    reset = 1'b0;
    @(negedge clk);
    check("midrst_no_we", {31'd0, bus.reg_we}, 32'd0);
    check("midrst_ready", {bus.instr_ready, bus.busy, bus.core_en}, 32'b101);
    check("midrst_aluc_s2", {bus.aluc, bus.s2}, {ALUC_CLEAR, MUXD_FROM_ALU});
    check("midrst_sel", {bus.x, bus.y, bus.z, bus.I}, 32'd0);
    check("midrst_flags", {bus.illegal_op, bus.mem_err, bus.mem_req, bus.mem_we}, 32'd0);
    check("midrst_retired", bus.retired, 32'd0);

    // Retire counter wrap on a 3-bit instance fed back-to-back NOPs.
    bus2.instr_valid = 1'b1;
    reset            = 1'b1;
    for (int g = 0; g < 60; g++) begin
      @(negedge clk);
      if (bus2.retired == 3'd7) break;
    end
    check("wrap_at_max", bus2.retired, 32'd7);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("wrap_to_zero", bus2.retired, 32'd0);
    check("idle_no_we", {31'd0, bus.reg_we}, 32'd0);
    bus2.instr_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
